// File: rtl/bspi_host.sv
// bspi_host: boot-SPI master that moves one 32-bit BIOS word per frame
// (SPI mode 0, MSB first) between a valid/ready command port and the SoC.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LEAD  | chip select low, first frame bit on io_sdi, SCK low one half-period
// SHIFT | SCK toggling, one bit per 2*CLK_DIV clk cycles
// TRAIL | SCK parked low, chip select still low for one half-period
// GAP   | chip select high for CS_GAP cycles before the next frame
module bspi_host #(
  parameter int CLK_DIV    = 4,
  parameter int DUMMY_BITS = 8,
  parameter int CS_GAP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_wmask,
  input  logic [10:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        io_bcf,
  output logic        io_scs,
  output logic        io_sck,
  output logic        io_sdi,
  input  logic        io_sdo
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(CS_GAP + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(CS_GAP - 1);
  localparam logic [6:0]       WR_BITS   = 7'd56;
  localparam logic [6:0]       RD_BITS   = 7'(56 + DUMMY_BITS);
  localparam logic [6:0]       DATA_BITS = 7'd32;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t             state;
  state_t             next_state;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [6:0]         bit_cnt;
  logic               phase_high;
  logic               is_rd;
  logic [55:0]        shift_reg;
  logic [31:0]        rx_reg;
  logic [55:0]        frame;
  logic               accept;
  logic               div_tc;
  logic               gap_tc;
  logic               last_bit;

  // Reads send zeros after the address; the dummy and data phases then shift
  // out the zero fill, keeping io_sdi low without a separate mux.
  assign frame = {cmd_wr ? {4'b1010, cmd_wmask} : 8'h30,
                  5'b0, cmd_addr,
                  cmd_wr ? cmd_wdata : 32'h0};

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign div_tc    = (div_cnt == '0);
  assign gap_tc    = (gap_cnt == '0);
  assign last_bit  = (bit_cnt == 7'd1);

  assign io_scs = !((state == LEAD) || (state == SHIFT) || (state == TRAIL));
  assign io_sck = (state == SHIFT) && phase_high;
  assign io_sdi = shift_reg[55];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; every exit is a down-counter reaching terminal count.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LEAD;
      LEAD:    if (div_tc) next_state = SHIFT;
      SHIFT:   if (div_tc && phase_high && last_bit) next_state = TRAIL;
      TRAIL:   if (div_tc) next_state = GAP;
      GAP:     if (gap_tc) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame datapath: timers, shift registers and read response.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      phase_high <= 1'b0;
      is_rd      <= 1'b0;
      shift_reg  <= '0;
      rx_reg     <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg  <= frame;
            is_rd      <= !cmd_wr;
            bit_cnt    <= cmd_wr ? WR_BITS : RD_BITS;
            div_cnt    <= DIV_LOAD;
            phase_high <= 1'b0;
          end
        end
        LEAD: begin
          div_cnt <= div_tc ? DIV_LOAD : div_cnt - DIV_W'(1);
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= DIV_LOAD;
            if (!phase_high) begin
              // Rising SCK: only the last 32 bits of a read carry data.
              phase_high <= 1'b1;
              if (is_rd && (bit_cnt <= DATA_BITS)) rx_reg <= {rx_reg[30:0], io_sdo};
            end else begin
              // Falling SCK: advance io_sdi to the next bit.
              phase_high <= 1'b0;
              shift_reg  <= {shift_reg[54:0], 1'b0};
              bit_cnt    <= bit_cnt - 7'd1;
              if (last_bit && is_rd) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= rx_reg;
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        TRAIL: begin
          if (div_tc) gap_cnt <= GAP_LOAD;
          else        div_cnt <= div_cnt - DIV_W'(1);
        end
        GAP: begin
          if (!gap_tc) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Boot-control flag follows boot_en one cycle late, independent of frames.
  always_ff @(posedge clk) begin
    if (rst) io_bcf <= 1'b0;
    else     io_bcf <= boot_en;
  end

endmodule
